// File: rtl/uart_rx_vote.sv
// uart_rx_vote: 8N1 UART receiver with a two-flop synchroniser, a 2-of-3
// majority vote around mid-bit, false-start rejection and frame-error
// reporting. It presents bytes on data_out with a one-cycle byte_ready strobe.
//
// Output handshake: byte_ready is a one-cycle strobe and data_out is valid
// in that same cycle. There is no back-pressure and no buffering, so the
// consumer must take data_out in the strobe cycle. data_out then holds until
// the next correctly framed byte. frame_error is a one-cycle strobe. It never
// coincides with byte_ready and it leaves data_out unchanged.
module uart_rx_vote #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial_in,
    output logic [7:0] data_out,
    output logic       byte_ready,
    output logic       frame_error,
    output logic       busy
);

    // Mid-bit sample index and the bit-timer width.
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HM1  = CW'(H - 1);
    localparam logic [CW-1:0] CNT_H    = CW'(H);
    localparam logic [CW-1:0] CNT_HP1  = CW'(H + 1);

    localparam logic [3:0] BIT_START = 4'd0;
    localparam logic [3:0] BIT_STOP  = 4'd9;

    // Receiver states.
    localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_RECV      = 2'd2;

    logic          r_sync1;
    logic          r_sync2;
    logic [1:0]    r_prime;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit_idx;
    logic          r_samp0;
    logic          r_samp1;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_byte_ready;
    logic          r_frame_error;

    logic          w_rxs;
    logic          w_vote;

    // The synchronised line and the 2-of-3 vote. The vote uses the samples
    // taken at H-1 and H, plus the live sample in the H+1 cycle.
    assign w_rxs  = r_sync2;
    assign w_vote = (r_samp0 & r_samp1) | (r_samp0 & w_rxs) | (r_samp1 & w_rxs);

    assign data_out    = r_data;
    assign byte_ready  = r_byte_ready;
    assign frame_error = r_frame_error;
    assign busy        = (r_state != ST_IDLE);

    // Two-flop synchroniser for the asynchronous serial line (idle-high reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_serial_in;
            r_sync2 <= r_sync1;
        end
    end

    // Marks when the synchroniser holds real line samples after reset release.
    // Until then, r_sync2 still shows its reset value of 1. Without this gate,
    // a line held low across reset would look idle for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prime <= 2'b00;
        end else begin
            r_prime <= {r_prime[0], 1'b1};
        end
    end

    // Receive FSM: bit timer, mid-bit voting, shifting and framing decisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_WAIT_IDLE;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_samp0       <= 1'b0;
            r_samp1       <= 1'b0;
            r_shift       <= 8'h00;
            r_data        <= 8'h00;
            r_byte_ready  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_byte_ready  <= 1'b0;
            r_frame_error <= 1'b0;
            case (r_state)
                ST_WAIT_IDLE: begin
                    if (r_prime[1] && w_rxs) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (!w_rxs) begin
                        r_state   <= ST_RECV;
                        r_cnt     <= '0;
                        r_bit_idx <= BIT_START;
                    end
                end
                ST_RECV: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        r_bit_idx <= r_bit_idx + 4'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (r_cnt == CNT_HM1) begin
                        r_samp0 <= w_rxs;
                    end
                    if (r_cnt == CNT_H) begin
                        r_samp1 <= w_rxs;
                    end
                    // Framing decisions are made at H+1. For the stop bit,
                    // this lets the next start edge arrive early.
                    if (r_cnt == CNT_HP1) begin
                        if (r_bit_idx == BIT_START) begin
                            if (w_vote) begin
                                r_state <= ST_IDLE;
                            end
                        end else if (r_bit_idx == BIT_STOP) begin
                            if (w_vote) begin
                                r_data       <= r_shift;
                                r_byte_ready <= 1'b1;
                                r_state      <= ST_IDLE;
                            end else begin
                                r_frame_error <= 1'b1;
                                r_state       <= ST_WAIT_IDLE;
                            end
                        end else begin
                            r_shift <= {w_vote, r_shift[7:1]};
                        end
                    end
                end
                default: begin
                    r_state <= ST_WAIT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_vote.sv
// Testbench for uart_rx_vote: the driver serialises frames and pushes the
// expected outcome (good byte, or frame error with data_out unchanged) into
// exp_q. An independent negedge monitor pops and compares on every pulse.
module tb_uart_rx_vote;

    localparam int CPB = 20;
    localparam int H   = CPB / 2;
    // Falling edge to first RECV cycle is 3 clocks. The stop-bit decision
    // lands 9 bits plus H+2 clocks after that.
    localparam int BR_LAT = 3 + 9 * CPB + H + 2;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       byte_ready;
    logic       frame_error;
    logic       busy;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         start_cyc = 0;
    logic       lat_en = 1'b0;
    logic       prev_br = 1'b0;
    logic [7:0] last_good = 8'h00;
    logic [8:0] exp_q[$];

    uart_rx_vote #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_serial_in (rx),
        .data_out     (data_out),
        .byte_ready   (byte_ready),
        .frame_error  (frame_error),
        .busy         (busy)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Holds the line at v for n clocks. Returns at posedge+1.
    task automatic hold(input logic v, input int n);
        repeat (n) begin
            rx = v;
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one 8N1 frame, optionally with a single-clock inverted glitch.
    // Reference model: a frame yields its byte when the stop bit is high.
    // Otherwise it yields a frame error and the previous byte stays visible.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int g_slot, input int g_off);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        if (stop) begin
            exp_q.push_back({1'b0, b});
            last_good = b;
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
        start_cyc = cyc;
        for (int s = 0; s < 10; s++) begin
            for (int o = 0; o < CPB; o++) begin
                rx = (s == g_slot && o == g_off) ? ~f[s] : f[s];
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Scoreboard monitor: compares every DUT pulse against the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_ready || frame_error) begin
                check("exclusive", {31'd0, byte_ready & frame_error}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: br=%0b fe=%0b data=%02h, expected no pulse (cycle %0d)",
                             byte_ready, frame_error, data_out, cyc);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("pulse_kind", {31'd0, frame_error}, {31'd0, e[8]});
                    check("data_out", {24'd0, data_out}, {24'd0, e[7:0]});
                end
                if (byte_ready) begin
                    check("br_width", {31'd0, prev_br}, 32'd0);
                end
                if (byte_ready && lat_en) begin
                    check("latency", cyc - start_cyc, BR_LAT);
                    lat_en = 1'b0;
                end
            end
            prev_br = byte_ready;
        end else begin
            prev_br = 1'b0;
        end
    end

    initial begin
        logic [9:0] f96;
        int         t0;
        int         guard;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_data", {24'd0, data_out}, 32'd0);
        check("rst_br", {31'd0, byte_ready}, 32'd0);
        check("rst_fe", {31'd0, frame_error}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(1'b1, 10);
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        // Single byte with latency check.
        lat_en = 1'b1;
        send_frame(8'hA5, 1'b1, -1, 0);
        hold(1'b1, 5);
        @(negedge clk);
        check("a5_busy_after", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back bytes with zero idle gap.
        for (int i = 1; i <= 8; i++) begin
            send_frame(i[7:0], 1'b1, -1, 0);
        end
        hold(1'b1, 20);

        // False start: 5-clock low pulse.
        t0 = cyc;
        hold(1'b0, 5);
        rx = 1'b1;
        @(negedge clk);
        check("fs_busy_high", {31'd0, busy}, 32'd1);
        while (cyc < t0 + 3 + H + 3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("fs_busy_low", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        hold(1'b1, 40);

        // Good byte, framing error with a long break, then recovery.
        send_frame(8'hC3, 1'b1, -1, 0);
        hold(1'b1, 20);
        send_frame(8'h3C, 1'b0, -1, 0);
        hold(1'b0, 60);
        hold(1'b1, 20);
        @(negedge clk);
        check("fe_data_hold", {24'd0, data_out}, 32'hC3);
        @(posedge clk);
        #1;
        send_frame(8'h7E, 1'b1, -1, 0);
        hold(1'b1, 20);

        // Single-clock glitches inside the vote window.
        send_frame(8'h00, 1'b1, 3, H + 1);
        hold(1'b1, 20);
        send_frame(8'hFF, 1'b1, 6, H);
        hold(1'b1, 20);

        // Random bytes, random data-bit glitches and random gaps.
        for (int i = 0; i < 8; i++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1,
                       int'($urandom_range(1, 8)), int'($urandom_range(1, CPB - 1)));
            hold(1'b1, int'($urandom_range(0, 30)));
        end
        hold(1'b1, 20);

        // Reset during a low data bit of 0x96, released with the line still low.
        f96 = {1'b1, 8'h96, 1'b0};
        for (int s = 0; s < 4; s++) begin
            hold(f96[s], CPB);
        end
        hold(f96[4], 5);
        rst_n = 1'b0;
        last_good = 8'h00;
        hold(1'b0, 5);
        rst_n = 1'b1;
        for (int i = 0; i < 110; i++) begin
            rx = 1'b0;
            @(negedge clk);
            if (i % 10 == 0) begin
                check("rr_busy", {31'd0, busy}, 32'd1);
                check("rr_data", {24'd0, data_out}, 32'd0);
                check("rr_pulse", {30'd0, byte_ready, frame_error}, 32'd0);
            end
            @(posedge clk);
            #1;
        end
        hold(1'b1, 20);
        send_frame(8'h55, 1'b1, -1, 0);
        hold(1'b1, 20);

        // Drain the scoreboard with a bounded wait.
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        check("queue_drain", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_vote.md
Name: uart_rx_vote

Overview:
- Upstream serial front end that feeds the 2x2 matrix multiplier's input loader: converts the 8N1 UART line on ui_in[0] into bytes plus a one-cycle ready strobe.
- Improves on a plain mid-bit receiver with a two-flop synchroniser, a 3-sample majority vote per bit, false-start rejection, frame-error reporting and re-arm after reset.
- Drop-in for the loader's byte interface: data_out/byte_ready semantics match what the loader consumes.

Parameters:
- CLKS_PER_BIT, 868, clocks per bit (100 MHz / 115200); legal range >= 8; simulation uses 20.
- H (localparam), CLKS_PER_BIT/2, mid-bit sample index.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- rx_serial_in  in  1  raw UART line, idle high, asynchronous to clk
- data_out  out  8  last correctly framed byte, LSB received first
- byte_ready  out  1  one-cycle pulse; data_out is valid in the same cycle
- frame_error  out  1  one-cycle pulse when the stop bit votes 0
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async): sync flops = 1, state = WAIT_IDLE, counters = 0, data_out = 0x00, byte_ready = 0, frame_error = 0, busy = 1.
- Synchroniser: two flops; only the second flop output ("rxs") is used. Latency is 2 clocks.
- Bit timer: cnt runs 0..CLKS_PER_BIT-1, and bit_idx runs 0 (start), 1..8 (data), 9 (stop).
- Sampling: rxs is captured at cnt = H-1, H and H+1. The vote (2-of-3) is evaluated in the cycle where cnt = H+1, including that cycle's rxs.
- States:
  - WAIT_IDLE: go to IDLE when rxs = 1. Prevents a line that is low at reset release from being taken as a start bit.
  - IDLE: when rxs = 0, go to RECV with cnt = 0, bit_idx = 0. busy rises the next cycle.
  - RECV, bit_idx 0, vote = 1: false start. Go to IDLE with no pulses.
  - RECV, bit_idx 0, vote = 0: continue.
  - RECV, bit_idx 1..8: shift the vote into the shift register, LSB first.
  - RECV, end of bit: at cnt = CLKS_PER_BIT-1, set cnt = 0 and bit_idx += 1.
  - RECV, bit_idx 9, vote = 1: data_out <= shift register, byte_ready <= 1, go to IDLE.
  - RECV, bit_idx 9, vote = 0: frame_error <= 1, data_out unchanged, go to WAIT_IDLE.
- Early return: the stop-bit decision is taken at mid-stop, so the next start edge can arrive as early as cnt = H+2 of the stop bit.
- Timing: with cycle 0 = first cycle in RECV, byte_ready is high in cycle 9*CLKS_PER_BIT + H + 2. It is never high for more than 1 cycle.
- Exclusivity: byte_ready and frame_error are never high together.
- No buffering. The consumer must take data_out in the byte_ready cycle; data_out holds until the next good byte.
- Reset mid-frame: the partial byte is discarded, with no pulse after release. Reception restarts only after the line is seen high.
- Break (line held low for any duration): exactly one frame_error, then wait in WAIT_IDLE.

Test Plan:
(CLKS_PER_BIT = 20, H = 10, 8N1, 1-bit idle gaps unless stated.)
1. Send 0xA5 -> byte_ready exactly 1 cycle, 192 cycles after RECV entry; data_out = 0xA5; frame_error = 0; busy = 0 afterwards.
2. Send 0x01..0x08 back-to-back with zero idle gap -> 8 byte_ready pulses with data_out 0x01..0x08 in order, no frame_error. This matches the loader filling A0..A3, B0..B3.
3. Pull the line low for 5 clocks, then hold high -> no byte_ready, no frame_error; busy falls within H+3 clocks of entering RECV.
4. Send 0xC3, then 0x3C with stop bit = 0, hold low 60 clocks, then send 0x7E:
   - one frame_error pulse;
   - data_out stays 0xC3 until 0x7E is received;
   - byte_ready pulses only for 0xC3 and 0x7E.
5. Send 0x00 with a 1-clock high glitch at cnt = H of data bit 3 -> data_out = 0x00. Send 0xFF with a 1-clock low glitch at cnt = H-1 of bit 6 -> data_out = 0xFF.
6. Assert rst_n low during data bit 4 of 0x96 while the line is low; release while the line is still low:
   - outputs are 0 and busy = 1 through the remainder of the frame;
   - no pulse from the aborted frame;
   - a following 0x55 gives byte_ready with data_out = 0x55.
